// File: rtl/ux607_ilm_preload_ctrl_if.sv
// -----------------------------------------------------------------------------
// ux607_ilm_preload_ctrl_if
// Bundle of every non-clock/reset signal of the ILM preload controller.
//   Control : start, zero_fill, base_addr, word_cnt -> busy, done
//   Bytes   : byte_vld, byte_dat -> byte_rdy (image byte stream)
//   Core    : core_req/we/addr/wdat/wmask -> core_gnt (core ILM access port)
//   SRAM    : ram_cs, ram_we, ram_addr, ram_wdat[39:0], ram_wem
// Modport slave is the controller's view; master is the surrounding system.
// -----------------------------------------------------------------------------
interface ux607_ilm_preload_ctrl_if #(
  parameter int AW = 14
);
  logic          start;
  logic          zero_fill;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_cnt;
  logic          busy;
  logic          done;

  logic          byte_vld;
  logic          byte_rdy;
  logic [7:0]    byte_dat;

  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [31:0]   core_wdat;
  logic [3:0]    core_wmask;
  logic          core_gnt;

  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [39:0]   ram_wdat;
  logic [3:0]    ram_wem;

  modport slave (
    input  start, zero_fill, base_addr, word_cnt,
    input  byte_vld, byte_dat,
    input  core_req, core_we, core_addr, core_wdat, core_wmask,
    output busy, done, byte_rdy, core_gnt,
    output ram_cs, ram_we, ram_addr, ram_wdat, ram_wem
  );

  modport master (
    output start, zero_fill, base_addr, word_cnt,
    output byte_vld, byte_dat,
    output core_req, core_we, core_addr, core_wdat, core_wmask,
    input  busy, done, byte_rdy, core_gnt,
    input  ram_cs, ram_we, ram_addr, ram_wdat, ram_wem
  );
endinterface

// File: rtl/ux607_ilm_preload_ctrl.sv
// -----------------------------------------------------------------------------
// ux607_ilm_preload_ctrl
// Fills the ILM SRAM from a little-endian byte stream (or with zeros) after a
// start request, and otherwise passes core ILM accesses straight to the SRAM.
// The preload engine owns the SRAM while busy; the core is granted only in IDLE.
//
// Ports:
//   clk  - single clock, all state on rising edge
//   rst  - synchronous, active-high reset
//   bus  - ux607_ilm_preload_ctrl_if.slave (control, byte stream, core, SRAM)
//
// Optional feature: define UX607_ILM_PRELOAD_ECC_EN to append a 7-bit SEC-DED
// code in ram_wdat[38:32] on every SRAM write; otherwise ram_wdat[39:32] = 0.
// -----------------------------------------------------------------------------
module ux607_ilm_preload_ctrl #(
  parameter int AW = 14
) (
  input  logic                         clk,
  input  logic                         rst,
  ux607_ilm_preload_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   base_q;
  logic [AW:0]     cnt_q;
  logic [AW:0]     idx_q;
  logic            zf_q;
  logic [1:0]      lane_q;
  logic [3:0][7:0] lanes_q;
  logic            busy_q;
  logic            done_q;
  logic            rdy_q;
  logic            wr_q;

  logic [AW:0]     idx_inc;
  assign idx_inc = idx_q + {{AW{1'b0}}, 1'b1};

  // Single FSM block; busy/done/byte_rdy/write strobe are registered alongside
  // the state so every output is a flop, not decoded state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      zf_q    <= 1'b0;
      lane_q  <= '0;
      lanes_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            base_q  <= bus.base_addr;
            cnt_q   <= bus.word_cnt;
            zf_q    <= bus.zero_fill;
            idx_q   <= '0;
            lane_q  <= '0;
            lanes_q <= '0;
            busy_q  <= 1'b1;
            if (bus.word_cnt == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (bus.zero_fill) begin
              state_q <= S_WRITE;
              wr_q    <= 1'b1;
            end else begin
              state_q <= S_COLLECT;
              rdy_q   <= 1'b1;
            end
          end
        end

        S_COLLECT: begin
          if (bus.byte_vld) begin
            lanes_q[lane_q] <= bus.byte_dat;
            lane_q          <= lane_q + 2'd1;  // wraps to lane 0 for next word
            if (lane_q == 2'd3) begin
              state_q <= S_WRITE;
              rdy_q   <= 1'b0;
              wr_q    <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          idx_q <= idx_inc;
          if (idx_inc == cnt_q) begin
            state_q <= S_DONE;
            wr_q    <= 1'b0;
            done_q  <= 1'b1;
          end else if (!zf_q) begin
            state_q <= S_COLLECT;
            wr_q    <= 1'b0;
            rdy_q   <= 1'b1;
          end
          // zero fill stays in WRITE: one word per cycle
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          rdy_q   <= 1'b0;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.byte_rdy = rdy_q;

  // Core access is combinational so a granted request reaches the SRAM in
  // the same cycle.
  logic gnt;
  assign gnt          = bus.core_req & (state_q == S_IDLE);
  assign bus.core_gnt = gnt;

  // A reset arriving while in WRITE must not let that cycle's write through.
  logic wr_act;
  assign wr_act = wr_q & ~rst;

  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wlo;
  logic [3:0]    ram_wem;

  always_comb begin
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_wlo  = '0;
    ram_wem  = '0;
    if (wr_act) begin
      ram_cs   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = base_q + idx_q[AW-1:0];  // truncation gives the mod 2^AW wrap
      ram_wlo  = zf_q ? 32'h0 : lanes_q;
      ram_wem  = 4'hF;
    end else if (gnt) begin
      ram_cs   = 1'b1;
      ram_we   = bus.core_we;
      ram_addr = bus.core_addr;
      ram_wlo  = bus.core_wdat;
      ram_wem  = bus.core_wmask;
    end
  end

`ifdef UX607_ILM_PRELOAD_ECC_EN
  // Hamming SEC-DED over 32 data bits: data occupy codeword positions 3..38
  // that are not powers of two; c[k] covers positions with bit k set, and c6
  // is overall parity of data plus c0..c5.
  function automatic logic [6:0] secded32(input logic [31:0] d);
    logic [6:0] c;
    int         di;
    c  = '0;
    di = 0;
    for (int p = 3; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int k = 0; k < 6; k++) begin
          if (p[k]) c[k] = c[k] ^ d[di[4:0]];
        end
        di++;
      end
    end
    c[6] = (^d) ^ (^c[5:0]);
    return c;
  endfunction

  assign bus.ram_wdat = {1'b0, secded32(ram_wlo), ram_wlo};
`else
  assign bus.ram_wdat = {8'h00, ram_wlo};
`endif

  assign bus.ram_cs   = ram_cs;
  assign bus.ram_we   = ram_we;
  assign bus.ram_addr = ram_addr;
  assign bus.ram_wem  = ram_wem;

endmodule

// File: tb/tb_ux607_ilm_preload_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ux607_ilm_preload_ctrl
// Directed bench: expected preload writes are queued when a preload is started
// and popped by a negedge monitor whenever the SRAM sees a non-core access.
// -----------------------------------------------------------------------------
module tb_ux607_ilm_preload_ctrl;
  localparam int AW = 14;

  logic clk;
  logic rst;

  ux607_ilm_preload_ctrl_if #(.AW(AW)) bus ();

  ux607_ilm_preload_ctrl #(.AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [39:0]   wdat;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

`ifdef UX607_ILM_PRELOAD_ECC_EN
  // Reference SEC-DED: place data bit i at the i-th non-power-of-two position.
  function automatic logic [6:0] tb_ecc(input logic [31:0] d);
    logic [6:0] c;
    int         pos;
    c   = '0;
    pos = 2;
    for (int i = 0; i < 32; i++) begin
      pos++;
      while ((pos & (pos - 1)) == 0) pos++;
      for (int k = 0; k < 6; k++)
        if (((pos >> k) & 1) == 1) c[k] = c[k] ^ d[i];
    end
    c[6] = (^d) ^ (^c[5:0]);
    return c;
  endfunction

  function automatic logic [39:0] exp_word(input logic [31:0] d);
    return {1'b0, tb_ecc(d), d};
  endfunction
`else
  function automatic logic [39:0] exp_word(input logic [31:0] d);
    return {8'h00, d};
  endfunction
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every SRAM access not owned by the core is a preload write.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.ram_cs && !bus.core_gnt) begin
      if (sb.size() == 0) begin
        n_assert++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_write: observed addr 0x%0h data 0x%0h expected no write",
                 bus.ram_addr, bus.ram_wdat);
        end
      end else begin
        e = sb.pop_front();
        $display("wr addr=0x%0h data=0x%0h (exp 0x%0h / 0x%0h)", bus.ram_addr, bus.ram_wdat, e.addr, e.wdat);
        check("wr_addr", 64'(bus.ram_addr), 64'(e.addr));
        check("wr_data", 64'(bus.ram_wdat), 64'(e.wdat));
        check("wr_we_wem", 64'({bus.ram_we, bus.ram_wem}), 64'(5'h1F));
      end
    end
  end

  // Caller is just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    bus.byte_vld = 1'b1;
    bus.byte_dat = b;
    for (int i = 0; i < 50; i++) begin
      if (bus.byte_rdy) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.byte_vld = 1'b0;
    check("byte_accepted", 64'(ok), 64'd1);
  endtask

  task automatic start_preload(input logic [AW-1:0] base, input logic [AW:0] cnt, input logic zf);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.word_cnt  = cnt;
    bus.zero_fill = zf;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.zero_fill = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    @(negedge clk);
    check("done_one_cycle", 64'(bus.done), 64'd0);
    check("busy_dropped", 64'(bus.busy), 64'd0);
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.zero_fill  = 1'b0;
    bus.base_addr  = '0;
    bus.word_cnt   = '0;
    bus.byte_vld   = 1'b0;
    bus.byte_dat   = '0;
    bus.core_req   = 1'b0;
    bus.core_we    = 1'b0;
    bus.core_addr  = '0;
    bus.core_wdat  = '0;
    bus.core_wmask = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_byte_rdy", 64'(bus.byte_rdy), 64'd0);
    check("rst_ram_cs", 64'(bus.ram_cs), 64'd0);
    @(posedge clk); #1;

    // Two collected words; a start pulse mid-collect must be ignored
    sb.push_back('{14'h0010, exp_word(32'h04030201)});
    sb.push_back('{14'h0011, exp_word(32'h08070605)});
    start_preload(14'h0010, 15'd2, 1'b0);
    @(negedge clk);
    check("collect_busy", 64'(bus.busy), 64'd1);
    check("collect_rdy", 64'(bus.byte_rdy), 64'd1);
    @(posedge clk); #1;
    send_byte(8'h01);
    send_byte(8'h02);
    start_preload(14'h0099, 15'd0, 1'b1);
    @(negedge clk);
    check("start_ignored_rdy", 64'(bus.byte_rdy), 64'd1);
    check("start_ignored_done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h05);
    send_byte(8'h06);
    send_byte(8'h07);
    send_byte(8'h08);
    wait_done(20);
    check("sb_empty_collect", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;

    // Zero fill across the address wrap, one write per cycle
    sb.push_back('{14'h3FFE, exp_word(32'h0)});
    sb.push_back('{14'h3FFF, exp_word(32'h0)});
    sb.push_back('{14'h0000, exp_word(32'h0)});
    start_preload(14'h3FFE, 15'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("zf_consecutive_cs", 64'(bus.ram_cs), 64'd1);
    end
    @(negedge clk);
    check("zf_done", 64'(bus.done), 64'd1);
    check("zf_no_extra_cs", 64'(bus.ram_cs), 64'd0);
    @(negedge clk);
    check("zf_busy_dropped", 64'(bus.busy), 64'd0);
    check("sb_empty_zf", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;

    // Zero word count: done one cycle after start, no write
    start_preload(14'h0020, 15'd0, 1'b0);
    @(negedge clk);
    check("cnt0_done", 64'(bus.done), 64'd1);
    check("cnt0_no_cs", 64'(bus.ram_cs), 64'd0);
    @(negedge clk);
    check("cnt0_done_clear", 64'(bus.done), 64'd0);
    check("cnt0_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;

    // Core request held through a preload
    sb.push_back('{14'h0200, exp_word(32'h0)});
    sb.push_back('{14'h0201, exp_word(32'h0)});
    sb.push_back('{14'h0202, exp_word(32'h0)});
    bus.core_req   = 1'b1;
    bus.core_we    = 1'b1;
    bus.core_addr  = 14'h0123;
    bus.core_wdat  = 32'hDEADBEEF;
    bus.core_wmask = 4'h5;
    start_preload(14'h0200, 15'd3, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      check("core_blocked", 64'(bus.core_gnt), 64'd0);
    end
    check("core_idle_reached", 64'(bus.busy), 64'd0);
    check("core_gnt_idle", 64'(bus.core_gnt), 64'd1);
    check("core_ram_cs", 64'(bus.ram_cs), 64'd1);
    check("core_ram_addr", 64'(bus.ram_addr), 64'h123);
    check("core_ram_we", 64'(bus.ram_we), 64'd1);
    check("core_ram_wem", 64'(bus.ram_wem), 64'h5);
    check("core_ram_wdat", 64'(bus.ram_wdat), 64'(exp_word(32'hDEADBEEF)));
    check("sb_empty_core", 64'(sb.size()), 64'd0);
    bus.core_we = 1'b0;
    #1;
    check("core_read_we", 64'(bus.ram_we), 64'd0);
    check("core_read_cs", 64'(bus.ram_cs), 64'd1);
    bus.core_req = 1'b0;
    #1;
    check("core_idle_cs", 64'(bus.ram_cs), 64'd0);
    @(posedge clk); #1;

    // Reset mid-collect, then a clean word
    start_preload(14'h0040, 15'd1, 1'b0);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstc_busy", 64'(bus.busy), 64'd0);
    check("rstc_rdy", 64'(bus.byte_rdy), 64'd0);
    @(posedge clk); #1;
    sb.push_back('{14'h0041, exp_word(32'hAABBCCDD)});
    start_preload(14'h0041, 15'd1, 1'b0);
    send_byte(8'hDD);
    send_byte(8'hCC);
    send_byte(8'hBB);
    send_byte(8'hAA);
    wait_done(20);
    check("sb_empty_rstc", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;

    // Reset mid-write: only the first zero word may reach the SRAM
    sb.push_back('{14'h0300, exp_word(32'h0)});
    start_preload(14'h0300, 15'd4, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstw_cs_gated", 64'(bus.ram_cs), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstw_busy", 64'(bus.busy), 64'd0);
    check("sb_empty_rstw", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;

`ifdef UX607_ILM_PRELOAD_ECC_EN
    bus.core_req   = 1'b1;
    bus.core_we    = 1'b1;
    bus.core_wmask = 4'hF;
    bus.core_wdat  = 32'h00000001;
    #1;
    check("ecc_one", 64'(bus.ram_wdat[39:32]), 64'h43);
    bus.core_wdat  = 32'h00000000;
    #1;
    check("ecc_zero", 64'(bus.ram_wdat[39:32]), 64'h00);
    bus.core_req   = 1'b0;
    @(posedge clk); #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ux607_ilm_preload_ctrl.md
UX607_ILM_PRELOAD_CTRL -- requirements
Module: ux607_ilm_preload_ctrl

Interface
REQ-001 The block SHALL have parameter AW, default 14, meaning the ILM word-address width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: single-cycle preload request, sampled only in IDLE.
REQ-005 The block SHALL have port zero_fill, input, 1 bit, sampled with start: 1 writes zero words without consuming the byte stream.
REQ-006 The block SHALL have port base_addr, input, AW bits: first ILM word address, sampled with start.
REQ-007 The block SHALL have port word_cnt, input, AW+1 bits: number of words to write, sampled with start.
REQ-008 The block SHALL have ports byte_vld (input, 1), byte_rdy (output, 1) and byte_dat (input, 8): the image byte stream, transferred when byte_vld and byte_rdy are both 1.
REQ-009 The block SHALL have ports busy (output, 1) and done (output, 1): busy means preload in progress; done is a one-cycle completion pulse.
REQ-010 The block SHALL have ports core_req (input, 1), core_we (input, 1), core_addr (input, AW), core_wdat (input, 32), core_wmask (input, 4) and core_gnt (output, 1): the core ILM access port.
REQ-011 The block SHALL have ports ram_cs (output, 1), ram_we (output, 1), ram_addr (output, AW), ram_wdat (output, 40) and ram_wem (output, 4): the ILM SRAM port.

Function
REQ-012 The block SHALL implement the states IDLE, COLLECT, WRITE and DONE.
REQ-013 IDLE with start=1 SHALL transition as follows, latching base_addr, word_cnt, zero_fill and clearing the word index:
- word_cnt=0 -> DONE, with no RAM write;
- zero_fill=1 -> WRITE;
- otherwise -> COLLECT.
REQ-014 In COLLECT, byte_rdy SHALL be 1; each accepted byte SHALL fill lanes 0,1,2,3 in order (little-endian); acceptance of the 4th byte SHALL transition to WRITE.
REQ-015 In WRITE, the block SHALL assert ram_cs=1, ram_we=1 and ram_wem=4'hF for exactly one cycle, with:
- ram_addr = (latched base + index) mod 2^AW;
- ram_wdat[31:0] = the packed word, or 0 if zero_fill.
REQ-016 After each WRITE, the index SHALL increment; when the index equals word_cnt the block SHALL go to DONE, otherwise back to COLLECT, or stay in WRITE when zero_fill (one word per cycle).
REQ-017 In DONE, done SHALL be 1 for one cycle, followed by IDLE.
REQ-018 busy SHALL be 1 in COLLECT, WRITE and DONE.
REQ-019 byte_rdy SHALL be 0 outside COLLECT.
REQ-020 start SHALL be ignored when not in IDLE.
REQ-021 Arbitration: core_gnt = core_req AND state==IDLE, combinationally; the preload engine has absolute priority while busy.
REQ-022 When granted, ram_cs=1, ram_we=core_we, ram_addr=core_addr, ram_wdat[31:0]=core_wdat and ram_wem=core_wmask, in the same cycle.
REQ-023 With no grant and no WRITE, ram_cs and ram_we SHALL be 0.
REQ-024 ram_wdat[39:32] SHALL be 0 unless the macro in REQ-028 is defined.
REQ-025 Address arithmetic SHALL wrap modulo 2^AW without error.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL enter IDLE and clear the index and lane registers; partially collected bytes are discarded.
REQ-027 The reset values of the outputs SHALL be busy=0, done=0 and byte_rdy=0, with ram_cs/ram_we following core_req per REQ-021; no preload write SHALL occur in a reset cycle, including a reset that arrives mid-COLLECT or mid-WRITE.

Configuration
REQ-028 With UX607_ILM_PRELOAD_ECC_EN defined, every RAM write (preload and core) SHALL carry ECC in ram_wdat as follows:
- ram_wdat[38:32] = the codebase's standard 32-bit SEC-DED code of ram_wdat[31:0];
- c0..c5 are Hamming parities;
- c6 is the XOR of all data bits and c0..c5;
- ram_wdat[39] = 0.
REQ-029 Without UX607_ILM_PRELOAD_ECC_EN, no ECC logic SHALL be present and ram_wdat[39:32]=0.

Verification
REQ-030 Scenario: start with base=0x10, cnt=2, bytes 01 02 03 04 05 06 07 08 -> writes 0x04030201@0x10 and 0x08070605@0x11; done pulses once; busy then drops to 0.
REQ-031 Scenario: zero_fill=1, base=0x3FFE, cnt=3 (AW=14) -> three consecutive-cycle writes of 0 to 0x3FFE, 0x3FFF and 0x0000.
REQ-032 Scenario: cnt=0 -> no ram_cs; done is asserted 1 cycle after start.
REQ-033 Scenario: core_req held high during a preload -> core_gnt=0 until IDLE; granted in the first IDLE cycle, with its address driven on ram_addr.
REQ-034 Scenario: rst asserted after 2 of 4 bytes, then a new preload of 0xAABBCCDD -> the written word is exactly 0xAABBCCDD, with no stale bytes.
REQ-035 Scenario (ECC_EN): write data 0x00000001 -> ram_wdat[39:32]=0x43; data 0 -> 0x00.
